// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared constants and entry layout for the a0 trace buffer.
//   TRACE_WIDTH    : default width of the traced a0 value
//   TRACE_DEPTH    : default FIFO depth (power of two, >= 2)
//   TRACE_TS_WIDTH : default timestamp width
//   trace_entry_t  : one FIFO entry {data, ts}; the ts field exists only when
//                    A0_TRACE_TIMESTAMP_EN is defined.
// -----------------------------------------------------------------------------
package trace_pkg;

   localparam int unsigned TRACE_WIDTH    = 32;
   localparam int unsigned TRACE_DEPTH    = 16;
   localparam int unsigned TRACE_TS_WIDTH = 16;

   typedef struct packed {
      logic [TRACE_WIDTH-1:0]    data;
`ifdef A0_TRACE_TIMESTAMP_EN
      logic [TRACE_TS_WIDTH-1:0] ts;
`endif
   } trace_entry_t;

endpackage : trace_pkg

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous show-ahead FIFO with synchronous clear. Pointers carry one extra
// wrap bit so full and empty are distinguishable; count is their difference.
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear, wins over push/pop
//   push_i       : write request; accepted when not full or when popping
//   pop_i        : read request; ignored when empty
//   wdata_i      : entry to write
//   rdata_o      : head entry, zero when empty
//   count_o      : entries held, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
// -----------------------------------------------------------------------------
module trace_fifo
   import trace_pkg::*;
#(
   parameter int unsigned DATA_W = TRACE_WIDTH,
   parameter int unsigned DEPTH  = TRACE_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DATA_W-1:0]          wdata_i,
   output logic [DATA_W-1:0]          rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PW-1:0]     count_c;
   logic              pop_ok_c;
   logic              push_ok_c;

   // Occupancy and handshake qualification
   assign count_c   = wr_ptr_q - rd_ptr_q;
   assign full_o    = (count_c == PW'(DEPTH));
   assign empty_o   = (count_c == '0);
   assign count_o   = count_c;
   assign pop_ok_c  = pop_i && !empty_o;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok_c = push_i && (!full_o || pop_ok_c);

   // Pointer next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are don't-care outside [rd, wr) so no reset is needed
   always_ff @(posedge clk) begin
      if (push_ok_c && !clr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

   // Show-ahead head, masked to zero when nothing is held
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule : trace_fifo

// File: rtl/a0_trace_buffer.sv
// -----------------------------------------------------------------------------
// a0_trace_buffer
// Records every change of the CPU a0 register (optionally with a cycle
// timestamp) into a show-ahead FIFO drained through a valid/ready port.
// Build option: A0_TRACE_TIMESTAMP_EN adds the free-running timestamp counter
// and per-entry timestamp storage; without it out_ts is tied to zero.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : capture enable (prev/primed frozen while low)
//   clr        : synchronous clear of FIFO, overflow, primed and timestamp
//   a0_i       : traced a0 value
//   out_valid  : head entry available
//   out_ready  : consumer accepts head
//   out_data   : head value (0 when empty)
//   out_ts     : head timestamp (0 when empty or timestamps disabled)
//   count      : entries held, 0..DEPTH
//   overflow   : sticky, set when a change was dropped on a full FIFO
// -----------------------------------------------------------------------------
module a0_trace_buffer
   import trace_pkg::*;
#(
   parameter int unsigned WIDTH    = TRACE_WIDTH,
   parameter int unsigned DEPTH    = TRACE_DEPTH,
   parameter int unsigned TS_WIDTH = TRACE_TS_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   input  logic [WIDTH-1:0]        a0_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [TS_WIDTH-1:0]     out_ts,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow
);

`ifdef A0_TRACE_TIMESTAMP_EN
   localparam int unsigned ENTRY_W = WIDTH + TS_WIDTH;
`else
   localparam int unsigned ENTRY_W = WIDTH;
`endif

   logic [WIDTH-1:0]   prev_q, prev_d;
   logic               primed_q, primed_d;
   logic               overflow_q, overflow_d;

   logic               capture_c;
   logic               pop_c;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   // Change detection: the first enabled cycle after reset/clear always logs
   assign capture_c = en && (!primed_q || (a0_i != prev_q));
   assign pop_c     = out_ready && !fifo_empty;

   // Change-detector and overflow next-state
   always_comb begin
      prev_d     = prev_q;
      primed_d   = primed_q;
      overflow_d = overflow_q;
      if (clr) begin
         primed_d   = 1'b0;
         overflow_d = 1'b0;
      end else if (capture_c) begin
         // prev advances even on a dropped push so the value is not re-logged
         prev_d   = a0_i;
         primed_d = 1'b1;
         if (fifo_full && !pop_c) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q     <= '0;
         primed_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         primed_q   <= primed_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef A0_TRACE_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;

   // Free-running timestamp, wraps silently
   always_comb begin
      ts_cnt_d = ts_cnt_q + TS_WIDTH'(1);
      if (clr) ts_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_cnt_q <= '0;
      else     ts_cnt_q <= ts_cnt_d;
   end

   assign push_entry = {a0_i, ts_cnt_q};
   assign out_data   = head_entry[ENTRY_W-1 -: WIDTH];
   assign out_ts     = head_entry[TS_WIDTH-1:0];
`else
   assign push_entry = a0_i;
   assign out_data   = head_entry;
   assign out_ts     = '0;
`endif

   trace_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .push_i  (capture_c),
      .pop_i   (out_ready),
      .wdata_i (push_entry),
      .rdata_o (head_entry),
      .count_o (count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign overflow  = overflow_q;

endmodule : a0_trace_buffer

// File: tb/tb_a0_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_a0_trace_buffer
// Scoreboard bench: the stimulus process runs a queue-based reference model and
// pushes expected entries; a negedge monitor compares the presented head
// against the scoreboard and retires entries on each accepted pop.
// -----------------------------------------------------------------------------
module tb_a0_trace_buffer;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned TS_WIDTH = 16;
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [WIDTH-1:0]    d;
      logic [TS_WIDTH-1:0] t;
   } exp_entry_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic                clr;
   logic [WIDTH-1:0]    a0;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_data;
   logic [TS_WIDTH-1:0] out_ts;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   a0_trace_buffer #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .TS_WIDTH (TS_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr       (clr),
      .a0_i      (a0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ts    (out_ts),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state (value after the most recent edge)
   exp_entry_t          exp_q[$];
   int                  m_cnt;
   logic [WIDTH-1:0]    m_prev;
   logic                m_primed;
   logic                m_ovf;
   logic [TS_WIDTH-1:0] m_ts;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_cnt    = 0;
      m_prev   = '0;
      m_primed = 1'b0;
      m_ovf    = 1'b0;
      m_ts     = '0;
   endtask

   // Called at posedge+1: check current state, drive next inputs, advance model
   task automatic step(input logic e, input logic c, input logic [WIDTH-1:0] v, input logic r);
      bit         cap;
      bit         popf;
      exp_entry_t ent;
      chk("count", 64'(count), 64'(m_cnt));
      chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (m_cnt == 0) begin
         chk("empty_data", 64'(out_data), 64'd0);
         chk("empty_ts", 64'(out_ts), 64'd0);
      end
      en = e; clr = c; a0 = v; out_ready = r;
      cap = e && (!m_primed || v != m_prev);
      if (c) begin
         exp_q.delete();
         m_cnt = 0; m_ovf = 1'b0; m_primed = 1'b0; m_ts = '0;
      end else begin
         popf = r && (m_cnt > 0);
         if (cap) begin
            m_prev = v; m_primed = 1'b1;
            if (m_cnt < DEPTH || popf) begin
               ent.d = v;
`ifdef A0_TRACE_TIMESTAMP_EN
               ent.t = m_ts;
`else
               ent.t = '0;
`endif
               exp_q.push_back(ent);
               m_cnt++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (popf) m_cnt--;
         m_ts = m_ts + TS_WIDTH'(1);
      end
      @(posedge clk); #1;
   endtask

   // Asynchronous reset mid-cycle; outputs must clear with no clock edge
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
   endtask

   // Monitor: head must match scoreboard front; retire on accepted pop
   always @(negedge clk) begin
      if (!rst && !clr && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_valid", 64'(out_valid), 64'd0);
         end else begin
            chk("head_data", 64'(out_data), 64'(exp_q[0].d));
            chk("head_ts", 64'(out_ts), 64'(exp_q[0].t));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; a0 = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;

      // Constant zero after reset: exactly one entry
      repeat (4) step(1'b1, 1'b0, '0, 1'b0);
      chk("prime_once_count", 64'(count), 64'd1);
      drain(2);

      // Repeated values collapse to distinct changes
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 1'b0, 32'd5, 1'b0);
      step(1'b1, 1'b0, 32'd5, 1'b0);
      step(1'b1, 1'b0, 32'd7, 1'b0);
      step(1'b1, 1'b0, 32'd7, 1'b0);
      step(1'b1, 1'b0, 32'd9, 1'b0);
      chk("dedup_count", 64'(count), 64'd3);
      drain(4);

      // Overflow: DEPTH+2 changes with no consumer
      for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, 32'(100 + i), 1'b0);
      chk("ovf_count", 64'(count), 64'(DEPTH));
      chk("ovf_flag", 64'(overflow), 64'd1);
      drain(DEPTH + 1);
      step(1'b0, 1'b1, '0, 1'b0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(200 + i), 1'b0);
      step(1'b1, 1'b0, 32'd999, 1'b1);
      chk("full_pp_count", 64'(count), 64'(DEPTH));
      chk("full_pp_ovf", 64'(overflow), 64'd0);
      drain(DEPTH + 1);

      // Changes while disabled are not recorded
      step(1'b1, 1'b0, 32'd3, 1'b0);
      step(1'b0, 1'b0, 32'd4, 1'b0);
      step(1'b0, 1'b0, 32'd3, 1'b0);
      step(1'b1, 1'b0, 32'd3, 1'b0);
      step(1'b1, 1'b0, 32'd3, 1'b0);
      chk("en_gate_count", 64'(count), 64'd1);
      drain(2);

      // Clear together with a change, then capture restarts at ts 0
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(300 + i), 1'b0);
      step(1'b1, 1'b1, 32'd77, 1'b0);
      chk("clr_count", 64'(count), 64'd0);
      chk("clr_valid", 64'(out_valid), 64'd0);
      chk("clr_ovf", 64'(overflow), 64'd0);
      step(1'b1, 1'b0, 32'd77, 1'b0);
      drain(2);

      // Reset in the middle of a drain
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(400 + i), 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      do_reset();
      step(1'b1, 1'b0, 32'd55, 1'b0);
      drain(2);

      // Randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         logic [WIDTH-1:0] v;
         v = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3));
         if (i == 300) do_reset();
         step(($urandom_range(0, 4) != 0), ($urandom_range(0, 39) == 0), v,
              ($urandom_range(0, 2) == 0));
      end
      drain(DEPTH + 2);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_a0_trace_buffer
